// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter that sequences N_REQ requesters onto one single-port
// memory with a fixed read latency, returning read data and a per-core ack.
module mem_rr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 64,
  parameter int RD_LAT    = 1,
  localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        rw,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        ack,
  output logic                    err,
  output logic [DATA_W-1:0]       rdata,
  output logic [IDX_W-1:0]        grant_id,
  output logic                    busy,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [15:0]             txn_count
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic               rw_lat_q, rw_lat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        txn_count_q, txn_count_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               err_q, err_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

  logic [ADDR_W-1:0]  addr_arr  [N_REQ];
  logic [DATA_W-1:0]  wdata_arr [N_REQ];
  logic [IDX_W-1:0]   pick;
  logic               pick_oor;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
  end

  // First requester found scanning upward from the one after the last winner.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               k;
    sel   = '0;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = (int'(last) + i) % N_REQ;
      if (!found && r[k]) begin
        found = 1'b1;
        sel   = k[IDX_W-1:0];
      end
    end
    return sel;
  endfunction

  assign pick     = rr_pick(req, last_q);
  assign pick_oor = {1'b0, addr_arr[pick]} >= DEPTH_L;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    rw_lat_d    = rw_lat_q;
    cnt_d       = cnt_q;
    txn_count_d = txn_count_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ack_d       = '0;
    err_d       = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d  = pick;
          last_d   = pick;
          rw_lat_d = rw[pick];
          // Out-of-range requests skip the memory and ack on the next cycle.
          if (pick_oor) begin
            state_d     = ACK;
            ack_d[pick] = 1'b1;
            err_d       = 1'b1;
          end else begin
            state_d     = ISSUE;
            mem_en_d    = 1'b1;
            mem_we_d    = rw[pick];
            mem_addr_d  = addr_arr[pick];
            mem_wdata_d = wdata_arr[pick];
          end
        end
      end
      ISSUE: begin
        if (rw_lat_q) begin
          state_d        = ACK;
          ack_d[grant_q] = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d        = mem_rdata;
          state_d        = ACK;
          ack_d[grant_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK: begin
        txn_count_d = txn_count_q + 16'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(N_REQ - 1);
      grant_q     <= '0;
      rw_lat_q    <= 1'b0;
      cnt_q       <= '0;
      txn_count_q <= '0;
      rdata_q     <= '0;
      ack_q       <= '0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      rw_lat_q    <= rw_lat_d;
      cnt_q       <= cnt_d;
      txn_count_q <= txn_count_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE);
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a transaction-level reference model.
module tb_mem_rr_arbiter;
  localparam int N_REQ = 4, ADDR_W = 8, DATA_W = 8, MEM_DEPTH = 64, RD_LAT = 1;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_REQ-1:0]        req, rw;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        ack;
  logic                    err, busy, mem_en, mem_we;
  logic [DATA_W-1:0]       rdata, mem_wdata, mem_rdata;
  logic [1:0]              grant_id;
  logic [ADDR_W-1:0]       mem_addr;
  logic [15:0]             txn_count;

  int vec_count  = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_rr_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                   .MEM_DEPTH(MEM_DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .grant_id(grant_id), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .txn_count(txn_count));

  // Memory attached to the arbiter (environment, RD_LAT = 1).
  logic [DATA_W-1:0] mem_arr [MEM_DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr[5:0]] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr[5:0]];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int c, input logic r, input logic w,
                       input logic [7:0] a, input logic [7:0] d);
    req[c] = r;
    rw[c]  = w;
    addr[c*ADDR_W +: ADDR_W]  = a;
    wdata[c*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = '0; rw = '0; addr = '0; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Waits (bounded) for an ack; lat counts rising edges since the call.
  task automatic wait_ack(output int idx, output int lat, output int men,
                          output logic [7:0] men_addr, output logic men_we);
    idx = -1; lat = 0; men = 0; men_addr = '0; men_we = 1'b0;
    while (idx < 0 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_en) begin
        men++;
        men_addr = mem_addr;
        men_we   = mem_we;
      end
      if (ack != '0) begin
        check("ack_onehot", 32'($onehot(ack)), 32'd1);
        for (int i = 0; i < N_REQ; i++) if (ack[i]) idx = i;
      end
    end
    if (idx < 0) begin
      vec_count++;
      miscompares++;
      $display("FAIL ack_timeout: no ack within %0d cycles, expected one", lat);
    end
  endtask

  typedef struct {
    int         core;
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    int         exp_lat;
    logic       exp_err;
    logic [7:0] exp_rdata;
    int         exp_men;
  } vec_t;

  task automatic run_random(input int cycles);
    logic [7:0]        model_mem [MEM_DEPTH];
    logic [N_REQ-1:0]  outstanding;
    logic [N_REQ-1:0]  exp_ack;
    logic [7:0]        exp_rdata, a, rd_val;
    logic [15:0]       exp_txn;
    int                n, last, w, k, lat, dec_edge, ack_edge, next_dec, exp_grant;
    logic              pending, w_err, w_rw, exp_men;
    for (int i = 0; i < MEM_DEPTH; i++) model_mem[i] = mem_arr[i];
    outstanding = '0; exp_rdata = '0; exp_txn = '0; rd_val = '0; a = '0;
    n = 0; last = N_REQ - 1; w = 0; dec_edge = 0; ack_edge = 0; next_dec = 0;
    exp_grant = 0; pending = 1'b0; w_err = 1'b0; w_rw = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      n++;
      // Advance the model over the rising edge just taken.
      if (pending && n == ack_edge + 1) begin
        pending  = 1'b0;
        exp_txn  = exp_txn + 16'd1;
        next_dec = n + 1;
      end
      if (!pending && n >= next_dec && req != '0) begin
        w = -1;
        for (int i = 1; i <= N_REQ && w < 0; i++) begin
          k = (last + i) % N_REQ;
          if (req[k]) w = k;
        end
        last = w; exp_grant = w;
        a     = addr[w*ADDR_W +: ADDR_W];
        w_rw  = rw[w];
        w_err = (a >= MEM_DEPTH);
        if (w_err)     lat = 1;
        else if (w_rw) lat = 2;
        else           lat = 2 + RD_LAT;
        if (!w_err) begin
          if (w_rw) model_mem[a[5:0]] = wdata[w*DATA_W +: DATA_W];
          else      rd_val = model_mem[a[5:0]];
        end
        pending = 1'b1; dec_edge = n; ack_edge = n + lat - 1;
      end
      exp_ack = '0;
      if (pending && n == ack_edge) begin
        exp_ack[w] = 1'b1;
        if (!w_err && !w_rw) exp_rdata = rd_val;
      end
      exp_men = pending && !w_err && (n == dec_edge);
      check("r_ack", 32'(ack), 32'(exp_ack));
      if (exp_ack != '0) begin
        check("r_err", 32'(err), 32'(w_err));
        $display("txn core=%0d %s addr=0x%02h err=%0d rdata=0x%02h txn_count=%0d",
                 w, w_rw ? "W" : "R", a, err, rdata, txn_count);
      end
      check("r_rdata", 32'(rdata), 32'(exp_rdata));
      check("r_grant", 32'(grant_id), 32'(exp_grant));
      check("r_busy", 32'(busy), 32'(pending));
      check("r_txn", 32'(txn_count), 32'(exp_txn));
      check("r_mem_en", 32'(mem_en), 32'(exp_men));
      // Stimulus: hold until ack, sometimes drop early after being granted.
      for (int c = 0; c < N_REQ; c++) begin
        if (exp_ack[c]) begin
          outstanding[c] = 1'b0;
          req[c] = 1'b0;
        end else if (outstanding[c] && pending && w == c && $urandom_range(0, 7) == 0) begin
          req[c] = 1'b0;
        end
        if (!outstanding[c] && (exp_ack[c] ? $urandom_range(0, 1) == 0 : $urandom_range(0, 3) == 0)) begin
          outstanding[c] = 1'b1;
          drive(c, 1'b1, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63)),
                8'($urandom));
        end
      end
    end
  endtask

  initial begin
    vec_t       tbl [6];
    int         idx, lat, men;
    logic [7:0] men_addr;
    logic       men_we;

    tbl[0] = '{1, 1'b1, 8'h05, 8'hA5, 2, 1'b0, 8'h00, 1};
    tbl[1] = '{1, 1'b0, 8'h05, 8'h00, 3, 1'b0, 8'hA5, 1};
    tbl[2] = '{2, 1'b0, 8'h40, 8'h00, 1, 1'b1, 8'hA5, 0};
    tbl[3] = '{0, 1'b1, 8'h3F, 8'h5A, 2, 1'b0, 8'hA5, 1};
    tbl[4] = '{3, 1'b0, 8'h3F, 8'h00, 3, 1'b0, 8'h5A, 1};
    tbl[5] = '{0, 1'b1, 8'hFF, 8'h11, 1, 1'b1, 8'h5A, 0};

    reset = 1'b0;
    req = '0; rw = '0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_txn", 32'(txn_count), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed single transactions.
    for (int v = 0; v < 6; v++) begin
      drive(tbl[v].core, 1'b1, tbl[v].w, tbl[v].a, tbl[v].d);
      wait_ack(idx, lat, men, men_addr, men_we);
      $display("txn core=%0d %s addr=0x%02h err=%0d rdata=0x%02h lat=%0d",
               tbl[v].core, tbl[v].w ? "W" : "R", tbl[v].a, err, rdata, lat);
      check("tbl_ack_idx", 32'(idx), 32'(tbl[v].core));
      check("tbl_latency", 32'(lat), 32'(tbl[v].exp_lat));
      check("tbl_err", 32'(err), 32'(tbl[v].exp_err));
      check("tbl_rdata", 32'(rdata), 32'(tbl[v].exp_rdata));
      check("tbl_mem_en_count", 32'(men), 32'(tbl[v].exp_men));
      check("tbl_grant", 32'(grant_id), 32'(tbl[v].core));
      if (tbl[v].exp_men != 0) begin
        check("tbl_mem_addr", 32'(men_addr), 32'(tbl[v].a));
        check("tbl_mem_we", 32'(men_we), 32'(tbl[v].w));
      end
      req[tbl[v].core] = 1'b0;
      @(negedge clk);
      check("tbl_idle_busy", 32'(busy), 32'd0);
      check("tbl_idle_ack", 32'(ack), 32'd0);
    end

    // All four cores contend and keep requesting: strict rotation.
    do_reset();
    for (int c = 0; c < N_REQ; c++) drive(c, 1'b1, 1'b1, 8'(c), 8'(8'h10 + c));
    for (int k = 0; k < 5; k++) begin
      wait_ack(idx, lat, men, men_addr, men_we);
      $display("txn core=%0d W rotation step=%0d lat=%0d", idx, k, lat);
      check("rot_grant", 32'(idx), 32'(k % N_REQ));
      check("rot_spacing", 32'(lat), (k == 0) ? 32'd2 : 32'd3);
    end
    @(negedge clk);
    check("rot_txn_count", 32'(txn_count), 32'd5);
    req = '0;
    @(negedge clk);

    // Core3 served, then core0 and core3 contend: core0 first.
    do_reset();
    drive(3, 1'b1, 1'b1, 8'h10, 8'h33);
    wait_ack(idx, lat, men, men_addr, men_we);
    check("cont_first", 32'(idx), 32'd3);
    req[3] = 1'b0;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 8'h05, 8'h00);
    drive(3, 1'b1, 1'b1, 8'h11, 8'h44);
    wait_ack(idx, lat, men, men_addr, men_we);
    $display("txn core=%0d R contention rdata=0x%02h", idx, rdata);
    check("cont_core0", 32'(idx), 32'd0);
    check("cont_rdata", 32'(rdata), 32'hA5);
    req[0] = 1'b0;
    wait_ack(idx, lat, men, men_addr, men_we);
    $display("txn core=%0d W contention", idx);
    check("cont_core3", 32'(idx), 32'd3);
    check("cont_spacing", 32'(lat), 32'd3);
    req[3] = 1'b0;
    @(negedge clk);

    // Reset while a read is waiting on memory.
    drive(2, 1'b1, 1'b0, 8'h05, 8'h00);
    @(negedge clk);
    check("mid_issue_mem_en", 32'(mem_en), 32'd1);
    @(negedge clk);
    check("mid_wait_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_mem_en", 32'(mem_en), 32'd0);
    check("mid_rst_txn", 32'(txn_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
    wait_ack(idx, lat, men, men_addr, men_we);
    $display("txn core=%0d R after reset rdata=0x%02h lat=%0d", idx, rdata, lat);
    check("post_rst_core0", 32'(idx), 32'd0);
    check("post_rst_lat", 32'(lat), 32'd3);
    check("post_rst_rdata", 32'(rdata), 32'h33);
    req[0] = 1'b0;
    wait_ack(idx, lat, men, men_addr, men_we);
    $display("txn core=%0d R retry rdata=0x%02h", idx, rdata);
    check("post_rst_core2", 32'(idx), 32'd2);
    check("post_rst_rdata2", 32'(rdata), 32'hA5);
    req[2] = 1'b0;
    @(negedge clk);

    // txn_count wrap: preload near the top, then two error acks.
    force dut.txn_count_q = 16'hFFFE;
    #1;
    release dut.txn_count_q;
    for (int k = 0; k < 2; k++) begin
      drive(1, 1'b1, 1'b0, 8'h80, 8'h00);
      wait_ack(idx, lat, men, men_addr, men_we);
      $display("txn core=%0d R addr=0x80 err=%0d", idx, err);
      check("wrap_err", 32'(err), 32'd1);
      req[1] = 1'b0;
      @(negedge clk);
      check("wrap_txn", 32'(txn_count), (k == 0) ? 32'hFFFF : 32'h0000);
    end

    // Randomised traffic against the reference model.
    do_reset();
    run_random(3000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
Round-robin arbiter and access sequencer that shares the single 64-entry x 8-bit memory between the four processor cores.
- Each core raises a request carrying rw, address and write data.
- The arbiter grants one core at a time and drives the memory port for that core.
- It waits the memory read latency, returns read data, and pulses a per-core ack.
- It sits between the four processor instances and the memory array in the top-level DUT.

Parameters:
N_REQ, 4, number of requesters (ack/grant widths follow it)
ADDR_W, 8, requester/memory address width
DATA_W, 8, data width
MEM_DEPTH, 64, valid address range 0..MEM_DEPTH-1
RD_LAT, 1, memory read latency in cycles from mem_en to mem_rdata valid (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  N_REQ  per-core request; held high with rw/addr/wdata stable until ack
rw  input  N_REQ  per-core direction: 1=write, 0=read
addr  input  N_REQ x ADDR_W  per-core address
wdata  input  N_REQ x DATA_W  per-core write data
ack  output  N_REQ  one-cycle completion pulse to the granted core
err  output  1  valid with ack; 1 = address out of range, no memory access made
rdata  output  DATA_W  read data; valid in the ack cycle of a read
grant_id  output  2  index of the current/last granted core
busy  output  1  high whenever state != IDLE
mem_en  output  1  memory access strobe, high for exactly one cycle per access
mem_we  output  1  write enable, qualified by mem_en
mem_addr  output  ADDR_W  memory address, valid with mem_en
mem_wdata  output  DATA_W  memory write data, valid with mem_en
mem_rdata  input  DATA_W  memory read data, valid RD_LAT cycles after mem_en
txn_count  output  16  count of completed acks (including err acks); wraps at 0xFFFF->0

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - state=IDLE.
  - ack=0, err=0, mem_en=0, mem_we=0.
  - mem_addr=0, mem_wdata=0, rdata=0.
  - grant_id=0, txn_count=0, busy=0.
  - Round-robin pointer last=N_REQ-1, so core 0 has top priority first.
- Reset mid-transaction aborts the access with no ack; a pending core must re-request.
- FSM states and transitions:
  - IDLE: if any req is high, select winner g = first set req scanning last+1, last+2, ... modulo N_REQ. Latch g, rw[g], addr[g], wdata[g]; grant_id<=g; last<=g.
    - addr[g] >= MEM_DEPTH: go to ACK with err=1.
    - Otherwise: go to ISSUE.
  - ISSUE: mem_en=1, mem_we=latched rw, mem_addr/mem_wdata=latched values.
    - Write: go to ACK.
    - Read: go to WAIT.
  - WAIT: lasts RD_LAT cycles. In its final cycle mem_rdata is registered into rdata. Then go to ACK.
  - ACK: ack[g]=1 for exactly one cycle; err as latched; txn_count+=1; then go to IDLE.
- Latency, with req sampled in IDLE at cycle t:
  - Write: mem_en at t+1, ack at t+2.
  - Read: mem_en at t+1, ack at t+2+RD_LAT.
  - Error: ack at t+1.
- Arbitration:
  - Decisions are made only in IDLE; requests arriving while busy wait.
  - A req dropped before ack is ignored once latched: the latched transaction completes and still acks.
- Fairness: a core that still holds req after its ack gets lowest priority on the next IDLE decision. Under continuous contention the grant order is strictly 0,1,2,3,0,...
- rdata holds its last read value across writes and err acks. err=0 on all non-error acks.
- Only one bit of ack is ever high. ack, mem_en and err are registered outputs (glitch-free).
- Simultaneous req from all four cores in IDLE: the winner is decided purely by the pointer; the others are served in rotation order, with no starvation.
- Back-to-back service: a new grant is evaluated in the IDLE cycle immediately following ACK, so there is one IDLE cycle between transactions.

Test Plan:
- Single write then read: core1 writes addr 0x05 data 0xA5. Expect mem_en/mem_we at t+1 and ack[1] at t+2. Core1 then reads 0x05 with RD_LAT=1. Expect ack[1] 3 cycles after sampling, rdata=0xA5, err=0.
- All four req high from reset, each holding req after ack: expect grant order 0,1,2,3,0 with ack spacing 3 cycles (writes). Expect txn_count=5 after the fifth ack.
- Out-of-range: core2 reads addr 0x40. Expect ack[2] and err=1 at t+1, mem_en never asserted, rdata unchanged from its previous value.
- Contention after rotation: core3 served last, then core0 and core3 both request. Expect core0 granted first, core3 second.
- Reset mid-read: assert reset=0 during WAIT. Expect busy, ack and mem_en at 0 immediately (asynchronous). After release, core0 is granted first and no stale ack appears.
- txn_count wrap: preload via 65535 err-acks (or force), one more ack. Expect txn_count=0.
